// File: rtl/minsec_stop_pkg.sv
// minsec_stop_pkg: shared state encoding, default wrap values and count widths
package minsec_stop_pkg;
    typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_e;
    localparam int CSEC_MAX_DEF = 99;
    localparam int SEC_MAX_DEF = 59;
    localparam int MIN_MAX_DEF = 59;
    localparam int MIN_W = 6;
    localparam int SEC_W = 6;
    localparam int CSEC_W = 7;
endpackage

// File: rtl/minsec_time_counter.sv
// minsec_time_counter: cascaded prescaler/csec/sec/min counter with clear and overflow pulse
module minsec_time_counter
    import minsec_stop_pkg::*;
#(
    parameter int TICKS_PER_CSEC = 10,
    parameter int CSEC_MAX = CSEC_MAX_DEF,
    parameter int SEC_MAX = SEC_MAX_DEF,
    parameter int MIN_MAX = MIN_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              clr_i,
    output logic [MIN_W-1:0]  min_o,
    output logic [SEC_W-1:0]  sec_o,
    output logic [CSEC_W-1:0] csec_o,
    output logic              overflow_o
);
    localparam int SUB_W = $clog2(TICKS_PER_CSEC + 1);
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [CSEC_W-1:0] csec_q, csec_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic ovf_q, c_inc, s_inc, m_inc, wrap;
    always_comb begin
        c_inc = en_i && sub_q == SUB_W'(TICKS_PER_CSEC - 1);
        s_inc = c_inc && csec_q == CSEC_W'(CSEC_MAX);
        m_inc = s_inc && sec_q == SEC_W'(SEC_MAX);
        wrap = m_inc && min_q == MIN_W'(MIN_MAX);
        sub_d = clr_i ? '0 : !en_i ? sub_q : c_inc ? '0 : sub_q + 1'b1;
        csec_d = clr_i ? '0 : !c_inc ? csec_q : s_inc ? '0 : csec_q + 1'b1;
        sec_d = clr_i ? '0 : !s_inc ? sec_q : m_inc ? '0 : sec_q + 1'b1;
        min_d = clr_i ? '0 : !m_inc ? min_q : wrap ? '0 : min_q + 1'b1;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_q <= '0;
            csec_q <= '0;
            sec_q <= '0;
            min_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            sub_q <= sub_d;
            csec_q <= csec_d;
            sec_q <= sec_d;
            min_q <= min_d;
            ovf_q <= wrap && !clr_i;
        end
    end
    // Next-state counts are exported so the display register adds only one cycle of latency.
    assign min_o = min_d;
    assign sec_o = sec_d;
    assign csec_o = csec_d;
    assign overflow_o = ovf_q;
endmodule

// File: rtl/minsec_stopwatch_ctrl.sv
// minsec_stopwatch_ctrl: stopwatch control FSM with live/lap-frozen registered display
module minsec_stopwatch_ctrl
    import minsec_stop_pkg::*;
#(
    parameter int TICKS_PER_CSEC = 10,
    parameter int CSEC_MAX = CSEC_MAX_DEF,
    parameter int SEC_MAX = SEC_MAX_DEF,
    parameter int MIN_MAX = MIN_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              btn_run_stop,
    input  logic              btn_clear,
    input  logic              btn_lap,
    output logic [MIN_W-1:0]  disp_min,
    output logic [SEC_W-1:0]  disp_sec,
    output logic [CSEC_W-1:0] disp_csec,
    output logic              running,
    output logic              lap_active,
    output logic              overflow,
    output logic              tick_gen_rst
);
    state_e state_q, state_d;
    logic [MIN_W-1:0] cnt_min, disp_min_q, disp_min_d;
    logic [SEC_W-1:0] cnt_sec, disp_sec_q, disp_sec_d;
    logic [CSEC_W-1:0] cnt_csec, disp_csec_q, disp_csec_d;
    logic running_q, lap_q, tgr_q, tgr_d, clr, en, hold;
    minsec_time_counter #(
        .TICKS_PER_CSEC(TICKS_PER_CSEC),
        .CSEC_MAX(CSEC_MAX),
        .SEC_MAX(SEC_MAX),
        .MIN_MAX(MIN_MAX)
    ) u_cnt (
        .clk(clk),
        .reset(reset),
        .en_i(en),
        .clr_i(clr),
        .min_o(cnt_min),
        .sec_o(cnt_sec),
        .csec_o(cnt_csec),
        .overflow_o(overflow)
    );
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = btn_run_stop ? RUN : IDLE;
            RUN:   state_d = btn_run_stop ? PAUSE : btn_lap ? LAP : RUN;
            LAP:   state_d = btn_run_stop ? PAUSE : btn_lap ? RUN : LAP;
            PAUSE: state_d = btn_clear ? IDLE : btn_run_stop ? RUN : PAUSE;
        endcase
        clr = state_q == PAUSE && btn_clear;
        en = tick && (state_q == RUN || state_q == LAP);
        tgr_d = (state_q == IDLE && btn_run_stop) || clr;
        // The display register itself holds the lap snapshot while staying in LAP.
        hold = state_q == LAP && state_d == LAP;
        disp_min_d = hold ? disp_min_q : cnt_min;
        disp_sec_d = hold ? disp_sec_q : cnt_sec;
        disp_csec_d = hold ? disp_csec_q : cnt_csec;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            disp_min_q <= '0;
            disp_sec_q <= '0;
            disp_csec_q <= '0;
            running_q <= 1'b0;
            lap_q <= 1'b0;
            tgr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            disp_min_q <= disp_min_d;
            disp_sec_q <= disp_sec_d;
            disp_csec_q <= disp_csec_d;
            running_q <= state_d == RUN || state_d == LAP;
            lap_q <= state_d == LAP;
            tgr_q <= tgr_d;
        end
    end
    assign disp_min = disp_min_q;
    assign disp_sec = disp_sec_q;
    assign disp_csec = disp_csec_q;
    assign running = running_q;
    assign lap_active = lap_q;
    assign tick_gen_rst = tgr_q;
endmodule

// File: tb/tb_minsec_stopwatch_ctrl.sv
// tb_minsec_stopwatch_ctrl: directed vector table plus corner-case sequences for the stopwatch
module tb_minsec_stopwatch_ctrl;
    logic clk, reset, tick, rs, cl, lp;
    logic [5:0] dmin, dsec;
    logic [6:0] dcsec;
    logic run, lapa, ovf, tgr;
    int total = 0, bad = 0;

    typedef struct {
        int t, r, c, l;
        int mn, sc, cs, ru, la, ov, tg;
    } vec_t;
    vec_t vecs[18];

    // Minutes wrap at 2 so the full-rollover case fits in a short run.
    minsec_stopwatch_ctrl #(
        .TICKS_PER_CSEC(1),
        .CSEC_MAX(99),
        .SEC_MAX(59),
        .MIN_MAX(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .btn_run_stop(rs),
        .btn_clear(cl),
        .btn_lap(lp),
        .disp_min(dmin),
        .disp_sec(dsec),
        .disp_csec(dcsec),
        .running(run),
        .lap_active(lapa),
        .overflow(ovf),
        .tick_gen_rst(tgr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int mn, input int sc, input int cs,
                           input int ru, input int la, input int ov, input int tg);
        chk({tag, ".min"}, dmin, mn);
        chk({tag, ".sec"}, dsec, sc);
        chk({tag, ".csec"}, dcsec, cs);
        chk({tag, ".running"}, run, ru);
        chk({tag, ".lap_active"}, lapa, la);
        chk({tag, ".overflow"}, ovf, ov);
        chk({tag, ".tick_gen_rst"}, tgr, tg);
    endtask

    task automatic step(input logic t, input logic r, input logic c, input logic l);
        tick = t; rs = r; cl = c; lp = l;
        @(posedge clk);
        #1;
        tick = 0; rs = 0; cl = 0; lp = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0);
    endtask

    task automatic do_reset();
        tick = 0; rs = 0; cl = 0; lp = 0;
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    initial begin
        int tg_seen;
        vecs[0]  = '{0,1,0,0, 0,0,0, 1,0,0,1};
        vecs[1]  = '{0,0,0,0, 0,0,0, 1,0,0,0};
        vecs[2]  = '{1,0,0,0, 0,0,1, 1,0,0,0};
        vecs[3]  = '{1,0,0,0, 0,0,2, 1,0,0,0};
        vecs[4]  = '{0,0,0,1, 0,0,2, 1,1,0,0};
        vecs[5]  = '{1,0,0,0, 0,0,2, 1,1,0,0};
        vecs[6]  = '{1,0,0,1, 0,0,4, 1,0,0,0};
        vecs[7]  = '{1,1,0,0, 0,0,5, 0,0,0,0};
        vecs[8]  = '{1,0,0,0, 0,0,5, 0,0,0,0};
        vecs[9]  = '{0,1,0,0, 0,0,5, 1,0,0,0};
        vecs[10] = '{0,0,1,0, 0,0,5, 1,0,0,0};
        vecs[11] = '{1,0,0,1, 0,0,6, 1,1,0,0};
        vecs[12] = '{0,1,0,0, 0,0,6, 0,0,0,0};
        vecs[13] = '{0,0,0,1, 0,0,6, 0,0,0,0};
        vecs[14] = '{0,0,1,0, 0,0,0, 0,0,0,1};
        vecs[15] = '{1,0,0,0, 0,0,0, 0,0,0,0};
        vecs[16] = '{0,0,0,1, 0,0,0, 0,0,0,0};
        vecs[17] = '{0,0,1,0, 0,0,0, 0,0,0,0};

        reset = 1; tick = 0; rs = 0; cl = 0; lp = 0;
        #12;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 0;

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].t[0], vecs[i].r[0], vecs[i].c[0], vecs[i].l[0]);
            chk_all($sformatf("vec%0d", i), vecs[i].mn, vecs[i].sc, vecs[i].cs,
                    vecs[i].ru, vecs[i].la, vecs[i].ov, vecs[i].tg);
        end

        // long run: 6100 ticks after a start, tick_gen_rst only once
        do_reset();
        step(0, 1, 0, 0);
        chk("start.tgr", tgr, 1);
        tg_seen = 0;
        for (int i = 0; i < 6100; i++) begin
            step(1, 0, 0, 0);
            tg_seen += int'(tgr);
        end
        chk("run6100.tgr_extra", tg_seen, 0);
        chk_all("run6100", 1, 1, 0, 1, 0, 0, 0);

        // lap freeze at 0:00:50, release at 0:00:80
        do_reset();
        step(0, 1, 0, 0);
        ticks(50);
        step(0, 0, 0, 1);
        ticks(30);
        chk_all("lapfreeze", 0, 0, 50, 1, 1, 0, 0);
        step(0, 0, 0, 1);
        chk_all("laprelease", 0, 0, 80, 1, 0, 0, 0);

        // stop coincident with tick is counted; paused ticks are not
        do_reset();
        step(0, 1, 0, 0);
        ticks(10);
        step(1, 1, 0, 0);
        chk_all("stoptick", 0, 0, 11, 0, 0, 0, 0);
        ticks(5);
        chk_all("pausehold", 0, 0, 11, 0, 0, 0, 0);

        // clear wins over run_stop in PAUSE
        step(0, 1, 1, 0);
        chk_all("clear", 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("clear.tgr_fall", tgr, 0);
        ticks(3);
        chk_all("idleticks", 0, 0, 0, 0, 0, 0, 0);

        // full rollover 2:59:99 -> 0:00:00 with overflow pulse
        do_reset();
        step(0, 1, 0, 0);
        ticks(17999);
        chk_all("premax", 2, 59, 99, 1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk_all("wrap", 0, 0, 0, 1, 0, 1, 0);
        step(1, 0, 0, 0);
        chk_all("postwrap", 0, 0, 1, 1, 0, 0, 0);

        // asynchronous reset mid-run at 0:12:34
        do_reset();
        step(0, 1, 0, 0);
        ticks(1234);
        chk_all("prereset", 0, 12, 34, 1, 0, 0, 0);
        #2;
        reset = 1;
        #1;
        chk_all("asyncreset", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 0;
        ticks(5);
        chk_all("afterreset", 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0);
        chk_all("restart", 0, 0, 0, 1, 0, 0, 1);
        step(1, 0, 0, 0);
        chk_all("restarttick", 0, 0, 1, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
